// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Digit-serial adder/subtractor. WIDTH-bit operands are processed DIGIT bits
// per clock, LSB digit first, through a DIGIT-bit ripple slice with a
// registered carry. Uses a start/busy/done handshake.
//
// Parameters:
//   WIDTH : operand/result width (>= 2)
//   DIGIT : bits processed per cycle (WIDTH % DIGIT == 0)
//
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   start        : request, sampled in IDLE or DONE
//   a, b         : operands, captured on accept
//   sub, cin     : 0 = add / 1 = subtract, carry-in / borrow-in
//   busy         : computation in progress
//   done         : one-cycle pulse, results valid
//   z            : result
//   cout         : carry-out (add) / not-borrow (sub)
//   ovf          : two's-complement overflow
//   zero, neg    : result flags, present only with SERIAL_ADD_FLAGS_EN
//
// Optional feature macro: SERIAL_ADD_FLAGS_EN
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
`ifdef SERIAL_ADD_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = DIGIT + 1;

    // Elaboration-time parameter legality
    generate
        if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_s_dig;
    logic [DIGIT:0]   w_slice;
    logic             w_c_msb;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // Ripple slice on the current (lowest) digit of the shifting operands
    assign w_a_dig = r_a[DIGIT-1:0];
    assign w_b_dig = r_b[DIGIT-1:0];
    assign w_slice = {1'b0, w_a_dig} + {1'b0, w_b_dig} + DW'(r_carry);
    assign w_s_dig = w_slice[DIGIT-1:0];
    // Carry into the top bit of the slice, recovered from its sum bit
    assign w_c_msb = w_slice[DIGIT-1] ^ w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1];
    assign w_last  = (r_cnt == CW'(N - 1));
    // New digit enters at the top; after N shifts the LSB digit sits at bit 0
    assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_s_dig) << (WIDTH - DIGIT));

`ifdef SERIAL_ADD_FLAGS_EN
    logic r_nz;
    logic r_zero;
    logic r_neg;
    logic w_nz_next;

    // Sticky "some digit was nonzero" avoids a wide NOR on z
    assign w_nz_next = r_nz | (|w_s_dig);
    assign zero      = r_zero;
    assign neg       = r_neg;
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_z     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
            r_nz    <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
`ifdef SERIAL_ADD_FLAGS_EN
                        r_nz    <= 1'b0;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
`ifdef SERIAL_ADD_FLAGS_EN
                    r_nz    <= w_nz_next;
`endif
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_z     <= w_sum_next;
                        r_cout  <= w_slice[DIGIT];
                        r_ovf   <= w_c_msb ^ w_slice[DIGIT];
`ifdef SERIAL_ADD_FLAGS_EN
                        r_zero  <= ~w_nz_next;
                        r_neg   <= w_sum_next[WIDTH-1];
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign z    = r_z;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Self-checking bench for serial_add_sub. Four instances (8/1, 8/2, 4/1, 4/4)
// share clock, reset and operands; each has its own start. Results are
// compared against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, b;
    logic       sub, cin;
    logic       st81, st82, st41, st44;

    logic       busy81, done81, cout81, ovf81;
    logic       busy82, done82, cout82, ovf82;
    logic       busy41, done41, cout41, ovf41;
    logic       busy44, done44, cout44, ovf44;
    logic [7:0] z81, z82;
    logic [3:0] z41, z44;
`ifdef SERIAL_ADD_FLAGS_EN
    logic       zero81, neg81, zero82, neg82, zero41, neg41, zero44, neg44;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d81 (
        .clk(clk), .reset(reset), .start(st81), .a(a), .b(b), .sub(sub), .cin(cin),
        .busy(busy81), .done(done81), .z(z81), .cout(cout81), .ovf(ovf81)
`ifdef SERIAL_ADD_FLAGS_EN
        , .zero(zero81), .neg(neg81)
`endif
    );
    serial_add_sub #(.WIDTH(8), .DIGIT(2)) u_d82 (
        .clk(clk), .reset(reset), .start(st82), .a(a), .b(b), .sub(sub), .cin(cin),
        .busy(busy82), .done(done82), .z(z82), .cout(cout82), .ovf(ovf82)
`ifdef SERIAL_ADD_FLAGS_EN
        , .zero(zero82), .neg(neg82)
`endif
    );
    serial_add_sub #(.WIDTH(4), .DIGIT(1)) u_d41 (
        .clk(clk), .reset(reset), .start(st41), .a(a[3:0]), .b(b[3:0]), .sub(sub), .cin(cin),
        .busy(busy41), .done(done41), .z(z41), .cout(cout41), .ovf(ovf41)
`ifdef SERIAL_ADD_FLAGS_EN
        , .zero(zero41), .neg(neg41)
`endif
    );
    serial_add_sub #(.WIDTH(4), .DIGIT(4)) u_d44 (
        .clk(clk), .reset(reset), .start(st44), .a(a[3:0]), .b(b[3:0]), .sub(sub), .cin(cin),
        .busy(busy44), .done(done44), .z(z44), .cout(cout44), .ovf(ovf44)
`ifdef SERIAL_ADD_FLAGS_EN
        , .zero(zero44), .neg(neg44)
`endif
    );

    // Reference: plain signed/unsigned integer arithmetic -> {ovf, cout, z[7:0]}
    function automatic logic [9:0] model(input int w, input logic [7:0] ia, input logic [7:0] ib,
                                         input logic is, input logic ic);
        longint m, ua, ub, sa, sb, r, sr;
        logic   co, ov;
        logic [7:0] zz;
        m  = longint'(1) << w;
        ua = longint'(ia) & (m - 1);
        ub = longint'(ib) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (!is) begin
            r  = ua + ub + longint'(ic);
            sr = sa + sb + longint'(ic);
            co = (r >= m);
        end else begin
            r  = ua - ub - longint'(ic);
            sr = sa - sb - longint'(ic);
            co = (r >= 0);
        end
        ov = (sr >= m / 2) || (sr < -(m / 2));
        zz = 8'(r & (m - 1));
        return {ov, co, zz};
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy81;
            1: return busy82;
            2: return busy41;
            default: return busy44;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0: return done81;
            1: return done82;
            2: return done41;
            default: return done44;
        endcase
    endfunction

    function automatic logic [9:0] get_res(input int d);
        case (d)
            0: return {ovf81, cout81, z81};
            1: return {ovf82, cout82, z82};
            2: return {ovf41, cout41, 4'h0, z41};
            default: return {ovf44, cout44, 4'h0, z44};
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0: st81 = v;
            1: st82 = v;
            2: st41 = v;
            default: st44 = v;
        endcase
    endtask

    // One operation: returns result, busy-cycle count and the cycle done was seen
    task automatic do_op(input int d, input logic [7:0] ia, input logic [7:0] ib,
                         input logic is, input logic ic,
                         output logic [9:0] res, output int nbusy, output int dcyc);
        @(negedge clk);
        a = ia; b = ib; sub = is; cin = ic;
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        // operands change after accept; must not affect the result
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        nbusy = 0;
        dcyc  = 1;
        while (!get_done(d) && dcyc < 40) begin
            if (get_busy(d)) nbusy++;
            @(negedge clk);
            dcyc++;
        end
        res = get_res(d);
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        for (int d = 0; d < 4; d++) begin
            obs = get_res(d);
            n_cmp++;
            if ({get_busy(d), get_done(d), obs} !== 12'h000) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got busy=%b done=%b res=%h, want all 0",
                         d, get_busy(d), get_done(d), obs);
            end
        end
    endtask

    task automatic test_add_d1();
        logic [9:0] res; int nb, dc;
        do_op(0, 8'h3C, 8'h05, 1'b0, 1'b0, res, nb, dc);
        n_cmp++;
        if (res !== {1'b0, 1'b0, 8'h41}) begin
            n_bad++; $display("FAIL add_d1 3C+05: got %h want %h", res, {1'b0, 1'b0, 8'h41});
        end
        n_cmp++;
        if (nb != 8 || dc != 9) begin
            n_bad++; $display("FAIL latency_d1: busy=%0d done_cycle=%0d want 8/9", nb, dc);
        end
    endtask

    task automatic test_add_d2();
        logic [9:0] res; int nb, dc;
        do_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, res, nb, dc);
        n_cmp++;
        if (res !== {1'b1, 1'b0, 8'h80}) begin
            n_bad++; $display("FAIL add_d2 7F+01: got %h want %h", res, {1'b1, 1'b0, 8'h80});
        end
        n_cmp++;
        if (nb != 4 || dc != 5) begin
            n_bad++; $display("FAIL latency_d2: busy=%0d done_cycle=%0d want 4/5", nb, dc);
        end
`ifdef SERIAL_ADD_FLAGS_EN
        n_cmp++;
        if ({zero82, neg82} !== 2'b01) begin
            n_bad++; $display("FAIL flags_d2 7F+01: got zero/neg=%b%b want 01", zero82, neg82);
        end
`endif
        do_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, res, nb, dc);
        n_cmp++;
        if (res !== {1'b0, 1'b1, 8'h00}) begin
            n_bad++; $display("FAIL add_d2 FF+01: got %h want %h", res, {1'b0, 1'b1, 8'h00});
        end
`ifdef SERIAL_ADD_FLAGS_EN
        n_cmp++;
        if ({zero82, neg82} !== 2'b10) begin
            n_bad++; $display("FAIL flags_d2 FF+01: got zero/neg=%b%b want 10", zero82, neg82);
        end
`endif
    endtask

    task automatic test_sub();
        logic [9:0] res; int nb, dc;
        do_op(0, 8'h05, 8'h07, 1'b1, 1'b0, res, nb, dc);
        n_cmp++;
        if (res !== {1'b0, 1'b0, 8'hFE}) begin
            n_bad++; $display("FAIL sub 05-07: got %h want %h", res, {1'b0, 1'b0, 8'hFE});
        end
        do_op(0, 8'h80, 8'h01, 1'b1, 1'b0, res, nb, dc);
        n_cmp++;
        if (res !== {1'b1, 1'b1, 8'h7F}) begin
            n_bad++; $display("FAIL sub 80-01: got %h want %h", res, {1'b1, 1'b1, 8'h7F});
        end
        do_op(0, 8'h10, 8'h01, 1'b1, 1'b1, res, nb, dc);
        n_cmp++;
        if (res !== {1'b0, 1'b1, 8'h0E}) begin
            n_bad++; $display("FAIL sub 10-01-1: got %h want %h", res, {1'b0, 1'b1, 8'h0E});
        end
    endtask

    task automatic test_random();
        logic [9:0] res, exp; int nb, dc;
        logic [7:0] ra, rb; logic rs, rc;
        for (int i = 0; i < 60; i++) begin
            int d;
            d  = i % 2;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            exp = model(8, ra, rb, rs, rc);
            do_op(d, ra, rb, rs, rc, res, nb, dc);
            n_cmp++;
            if (res !== exp) begin
                n_bad++;
                $display("FAIL random dut%0d a=%h b=%h sub=%b cin=%b: got %h want %h",
                         d, ra, rb, rs, rc, res, exp);
            end
`ifdef SERIAL_ADD_FLAGS_EN
            n_cmp++;
            if ((d == 0 ? {zero81, neg81} : {zero82, neg82}) !== {exp[7:0] == 8'h00, exp[7]}) begin
                n_bad++;
                $display("FAIL random_flags dut%0d: got %b want %b", d,
                         (d == 0 ? {zero81, neg81} : {zero82, neg82}), {exp[7:0] == 8'h00, exp[7]});
            end
`endif
        end
    endtask

    // start held high; accepts at edges 0, 9, 18, ... and done after edges 8, 17, ...
    task automatic test_back_to_back();
        logic [7:0] qa[0:45], qb[0:45];
        logic       qs[0:45], qc[0:45];
        logic [9:0] exp;
        @(negedge clk);
        for (int k = 0; k < 46; k++) begin
            qa[k] = 8'($urandom); qb[k] = 8'($urandom); qs[k] = 1'($urandom); qc[k] = 1'($urandom);
        end
        a = qa[0]; b = qb[0]; sub = qs[0]; cin = qc[0];
        st81 = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy81, done81} !== (((k % 9) == 8) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL b2b_handshake edge%0d: got busy/done=%b%b", k, busy81, done81);
            end
            if ((k % 9) == 8) begin
                exp = model(8, qa[k-8], qb[k-8], qs[k-8], qc[k-8]);
                n_cmp++;
                if ({ovf81, cout81, z81} !== exp) begin
                    n_bad++;
                    $display("FAIL b2b_result edge%0d: got %h want %h", k, {ovf81, cout81, z81}, exp);
                end
            end
            a = qa[k+1]; b = qb[k+1]; sub = qs[k+1]; cin = qc[k+1];
        end
        st81 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [9:0] res; int nb, dc, ndone;
        do_op(0, 8'h3C, 8'h05, 1'b0, 1'b0, res, nb, dc);
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0;
        st81 = 1'b1;
        @(negedge clk);
        st81 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy81, done81, ovf81, cout81, z81} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b done=%b res=%h want all 0",
                     busy81, done81, {ovf81, cout81, z81});
        end
        #1 reset = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done81 || busy81) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++; $display("FAIL reset_mid_no_done: activity cycles=%0d want 0", ndone);
        end
        do_op(0, 8'hA5, 8'h3C, 1'b1, 1'b0, res, nb, dc);
        n_cmp++;
        if (res !== model(8, 8'hA5, 8'h3C, 1'b1, 1'b0)) begin
            n_bad++;
            $display("FAIL reset_mid_recover: got %h want %h", res, model(8, 8'hA5, 8'h3C, 1'b1, 1'b0));
        end
    endtask

    task automatic test_exhaustive4();
        logic [9:0] res, exp; int nb, dc;
        for (int d = 2; d < 4; d++) begin
            for (int v = 0; v < 1024; v++) begin
                logic [7:0] ea, eb; logic es, ec;
                ea = 8'(v & 15); eb = 8'((v >> 4) & 15); ec = 1'((v >> 8) & 1); es = 1'((v >> 9) & 1);
                exp = model(4, ea, eb, es, ec);
                do_op(d, ea, eb, es, ec, res, nb, dc);
                n_cmp++;
                if (res !== exp) begin
                    n_bad++;
                    $display("FAIL exh4 dut%0d a=%h b=%h sub=%b cin=%b: got %h want %h",
                             d, ea, eb, es, ec, res, exp);
                end
            end
        end
        n_cmp++;
        if (nb != 1 || dc != 2) begin
            n_bad++; $display("FAIL latency_d44: busy=%0d done_cycle=%0d want 1/2", nb, dc);
        end
    endtask

    initial begin
        reset = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        st81 = 1'b0; st82 = 1'b0; st41 = 1'b0; st44 = 1'b0;
        #22;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_add_d1();
        test_add_d2();
        test_sub();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
